// File: rtl/memory_board.sv
// memory_board
// Clocked board engine for the memory card game. It tracks every card
// position, accepts two selections per turn and compares their pair IDs.
// A matching pair is retired. A mismatching pair stays face-up for
// HIDE_DELAY cycles and is then hidden. The engine also counts moves and
// found pairs and flags game over.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start_i        pulse: load layout_i and begin a new game (any state)
//   layout_i       pair ID per position, position p at [p*PID_W +: PID_W]
//   sel_valid_i    selection strobe, one cycle per selection
//   sel_pos_i      selected position
//   face_up_o      card shown (revealed this turn or matched)
//   matched_o      card retired from play
//   moves_o        completed compares, saturating
//   pairs_found_o  number of matched pairs
//   match_pulse_o  one-cycle pulse when a pair is retired
//   miss_pulse_o   one-cycle pulse when a compare fails
//   busy_o         compare / mismatch display in progress, selections ignored
//   game_over_o    all pairs found
module memory_board #(
  parameter int NUM_PAIRS  = 8,
  parameter int HIDE_DELAY = 25,
  parameter int MOVE_W     = 16,
  localparam int NCARDS = 2 * NUM_PAIRS,
  localparam int POS_W  = $clog2(NCARDS),
  localparam int PID_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [NCARDS*PID_W-1:0] layout_i,
  input  logic                    sel_valid_i,
  input  logic [POS_W-1:0]        sel_pos_i,
  output logic [NCARDS-1:0]       face_up_o,
  output logic [NCARDS-1:0]       matched_o,
  output logic [MOVE_W-1:0]       moves_o,
  output logic [PID_W:0]          pairs_found_o,
  output logic                    match_pulse_o,
  output logic                    miss_pulse_o,
  output logic                    busy_o,
  output logic                    game_over_o
);

  localparam int DLY_W = (HIDE_DELAY > 1) ? $clog2(HIDE_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD  = DLY_W'(HIDE_DELAY - 1);
  localparam logic [PID_W:0]   PAIRS_ALL = (PID_W + 1)'(NUM_PAIRS);
  localparam logic [POS_W:0]   NCARDS_W  = (POS_W + 1)'(NCARDS);

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    SECOND,
    COMPARE,
    SHOW_MISS,
    DONE
  } state_t;

  state_t                    state_q;
  logic [NCARDS*PID_W-1:0]   layout_q;
  logic [NCARDS-1:0]         face_up_q;
  logic [NCARDS-1:0]         matched_q;
  logic [MOVE_W-1:0]         moves_q;
  logic [PID_W:0]            pairs_found_q;
  logic                      match_pulse_q;
  logic                      miss_pulse_q;
  logic                      busy_q;
  logic                      game_over_q;
  logic [POS_W-1:0]          a_q;
  logic [POS_W-1:0]          b_q;
  logic [DLY_W-1:0]          dly_q;

  logic                      sel_legal;
  logic [PID_W-1:0]          id_a;
  logic [PID_W-1:0]          id_b;
  logic [PID_W:0]            pairs_found_d;

  // The range check comes first so an out-of-range position never
  // qualifies, even on boards whose size is not a power of two.
  assign sel_legal = sel_valid_i &&
                     ({1'b0, sel_pos_i} < NCARDS_W) &&
                     !face_up_q[sel_pos_i];

  assign id_a          = layout_q[int'(a_q) * PID_W +: PID_W];
  assign id_b          = layout_q[int'(b_q) * PID_W +: PID_W];
  assign pairs_found_d = pairs_found_q + 1'b1;

  // Single FSM process; every output is a register updated together with
  // the state, so busy/game_over follow the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      layout_q      <= '0;
      face_up_q     <= '0;
      matched_q     <= '0;
      moves_q       <= '0;
      pairs_found_q <= '0;
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
      busy_q        <= 1'b0;
      game_over_q   <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      dly_q         <= '0;
    end else begin
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
      if (start_i) begin
        layout_q      <= layout_i;
        face_up_q     <= '0;
        matched_q     <= '0;
        moves_q       <= '0;
        pairs_found_q <= '0;
        dly_q         <= '0;
        busy_q        <= 1'b0;
        game_over_q   <= 1'b0;
        state_q       <= FIRST;
      end else begin
        case (state_q)
          FIRST: begin
            if (sel_legal) begin
              face_up_q[sel_pos_i] <= 1'b1;
              a_q                  <= sel_pos_i;
              state_q              <= SECOND;
            end
          end
          SECOND: begin
            if (sel_legal) begin
              face_up_q[sel_pos_i] <= 1'b1;
              b_q                  <= sel_pos_i;
              busy_q               <= 1'b1;
              state_q              <= COMPARE;
            end
          end
          COMPARE: begin
            if (moves_q != '1) begin
              moves_q <= moves_q + 1'b1;
            end
            if (id_a == id_b) begin
              matched_q[a_q] <= 1'b1;
              matched_q[b_q] <= 1'b1;
              pairs_found_q  <= pairs_found_d;
              match_pulse_q  <= 1'b1;
              busy_q         <= 1'b0;
              if (pairs_found_d == PAIRS_ALL) begin
                game_over_q <= 1'b1;
                state_q     <= DONE;
              end else begin
                state_q <= FIRST;
              end
            end else begin
              miss_pulse_q <= 1'b1;
              dly_q        <= DLY_LOAD;
              state_q      <= SHOW_MISS;
            end
          end
          SHOW_MISS: begin
            // Loaded with HIDE_DELAY-1 so the cards stay up for exactly
            // HIDE_DELAY cycles after the compare cycle.
            if (dly_q == '0) begin
              face_up_q[a_q] <= 1'b0;
              face_up_q[b_q] <= 1'b0;
              busy_q         <= 1'b0;
              state_q        <= FIRST;
            end else begin
              dly_q <= dly_q - 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign face_up_o     = face_up_q;
  assign matched_o     = matched_q;
  assign moves_o       = moves_q;
  assign pairs_found_o = pairs_found_q;
  assign match_pulse_o = match_pulse_q;
  assign miss_pulse_o  = miss_pulse_q;
  assign busy_o        = busy_q;
  assign game_over_o   = game_over_q;

endmodule
